// File: rtl/game_sequencer.sv
// game_sequencer: control FSM for a 2048-style board datapath.
// Latency: an accepted press drives its direction code on the selector in the cycle after the press edge.
// Backpressure: none; presses outside IDLE are dropped, never queued.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   btn_up/down/left/right, btn_restart : synchronized active-high buttons (edge detected here)
//   cfg_win_exp       : win exponent for the next game (0 selects WIN_EXP_DEFAULT)
//   gano, perdio      : win / lose flags returned by the datapath
//   selector          : datapath command
//   condicion_gane    : win exponent latched at game start
//   busy, game_won, game_lost, move_count : status
module game_sequencer #(
   parameter int unsigned SETTLE_CYCLES   = 2,
   parameter logic [3:0]  WIN_EXP_DEFAULT = 4'b1011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_restart,
   input  logic [3:0]  cfg_win_exp,
   input  logic        gano,
   input  logic        perdio,
   output logic [2:0]  selector,
   output logic [3:0]  condicion_gane,
   output logic        busy,
   output logic        game_won,
   output logic        game_lost,
   output logic [15:0] move_count
);

   localparam logic [3:0] DWELL_LOAD = 4'(SETTLE_CYCLES - 1);

   localparam logic [2:0] SEL_INIT  = 3'b000;
   localparam logic [2:0] SEL_LEFT  = 3'b001;
   localparam logic [2:0] SEL_RIGHT = 3'b010;
   localparam logic [2:0] SEL_UP    = 3'b011;
   localparam logic [2:0] SEL_DOWN  = 3'b100;
   localparam logic [2:0] SEL_HOLD  = 3'b101;
   localparam logic [2:0] SEL_SPAWN = 3'b111;

   typedef enum logic [2:0] {INIT, SPAWN0, IDLE, MOVE, SPAWN, CHECK, WON, LOST} state_t;

   state_t      state, state_nxt;
   logic [3:0]  dwell;
   logic [2:0]  dir, dir_nxt;
   logic [2:0]  sel_nxt;
   logic        prev_up, prev_down, prev_left, prev_right, prev_restart;
   logic        up_e, down_e, left_e, right_e, restart_e;
   logic        entering;
   logic [3:0]  win_exp_sel;

   assign up_e      = btn_up      & ~prev_up;
   assign down_e    = btn_down    & ~prev_down;
   assign left_e    = btn_left    & ~prev_left;
   assign right_e   = btn_right   & ~prev_right;
   assign restart_e = btn_restart & ~prev_restart;

   assign win_exp_sel = (cfg_win_exp == 4'd0) ? WIN_EXP_DEFAULT : cfg_win_exp;

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      if (restart_e) begin
         state_nxt = INIT;
      end else begin
         case (state)
            INIT:   if (dwell == 4'd0) state_nxt = SPAWN0;
            SPAWN0: if (dwell == 4'd0) state_nxt = IDLE;
            IDLE: begin
               // Fixed priority so exactly one direction is latched.
               if (up_e) begin
                  state_nxt = MOVE; dir_nxt = SEL_UP;
               end else if (down_e) begin
                  state_nxt = MOVE; dir_nxt = SEL_DOWN;
               end else if (left_e) begin
                  state_nxt = MOVE; dir_nxt = SEL_LEFT;
               end else if (right_e) begin
                  state_nxt = MOVE; dir_nxt = SEL_RIGHT;
               end
            end
            MOVE:   if (dwell == 4'd0) state_nxt = SPAWN;
            SPAWN:  if (dwell == 4'd0) state_nxt = CHECK;
            CHECK: begin
               if (gano)        state_nxt = WON;
               else if (perdio) state_nxt = LOST;
               else             state_nxt = IDLE;
            end
            WON, LOST: state_nxt = state;
            default:   state_nxt = INIT;
         endcase
      end

      // A restart while already in INIT still counts as a fresh entry.
      entering = (state_nxt != state) || restart_e;

      // Outputs are decoded from the next state so the registers line up with the state.
      case (state_nxt)
         INIT:          sel_nxt = SEL_INIT;
         SPAWN0, SPAWN: sel_nxt = SEL_SPAWN;
         MOVE:          sel_nxt = dir_nxt;
         default:       sel_nxt = SEL_HOLD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= INIT;
         dwell          <= DWELL_LOAD;
         dir            <= SEL_HOLD;
         selector       <= SEL_INIT;
         condicion_gane <= win_exp_sel;
         move_count     <= 16'd0;
         busy           <= 1'b1;
         game_won       <= 1'b0;
         game_lost      <= 1'b0;
         prev_up        <= 1'b0;
         prev_down      <= 1'b0;
         prev_left      <= 1'b0;
         prev_right     <= 1'b0;
         prev_restart   <= 1'b0;
      end else begin
         prev_up      <= btn_up;
         prev_down    <= btn_down;
         prev_left    <= btn_left;
         prev_right   <= btn_right;
         prev_restart <= btn_restart;

         state    <= state_nxt;
         dir      <= dir_nxt;
         selector <= sel_nxt;

         if (entering)            dwell <= DWELL_LOAD;
         else if (dwell != 4'd0)  dwell <= dwell - 4'd1;

         busy      <= !(state_nxt == IDLE || state_nxt == WON || state_nxt == LOST);
         game_won  <= (state_nxt == WON);
         game_lost <= (state_nxt == LOST);

         if (entering && state_nxt == INIT) begin
            condicion_gane <= win_exp_sel;
            move_count     <= 16'd0;
         end else if (state == MOVE && state_nxt == SPAWN && move_count != 16'hFFFF) begin
            move_count <= move_count + 16'd1;
         end
      end
   end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: number of cycles each datapath command is held before the next step (legal range 1..15).
REQ-002 SHALL have parameter WIN_EXP_DEFAULT, default 4'b1011: win exponent used when cfg_win_exp is 0.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 btn_up, btn_down, btn_left, btn_right  input  1 each  already-synchronized, debounced, active-high direction buttons.
REQ-006 btn_restart  input  1  already-synchronized, active-high new-game request.
REQ-007 cfg_win_exp  input  4  win tile exponent requested for the next game.
REQ-008 gano, perdio  input  1 each  win and lose flags from the movement datapath.
REQ-009 selector  output  3  registered command to the movement datapath.
REQ-010 condicion_gane  output  4  registered win exponent sent to the datapath.
REQ-011 busy, game_won, game_lost  output  1 each  registered status flags.
REQ-012 move_count  output  16  registered count of accepted moves.

Function
REQ-013 Selector encoding SHALL be fixed:
- 000: init board
- 001: left
- 010: right
- 011: up
- 100: down
- 101: hold/no-op
- 111: spawn tile
- 110: never driven
REQ-014 FSM states SHALL be INIT, SPAWN0, IDLE, MOVE, SPAWN, CHECK, WON, LOST.
REQ-015 Selector per state SHALL be:
- INIT: 000
- SPAWN0: 111
- IDLE, CHECK, WON, LOST: 101
- MOVE: latched direction code
- SPAWN: 111
REQ-016 INIT, SPAWN0, MOVE and SPAWN SHALL each last exactly SETTLE_CYCLES cycles, timed by a 4-bit dwell counter that is reloaded on every state entry.
REQ-017 State transitions SHALL be:
- INIT to SPAWN0
- SPAWN0 to IDLE
- IDLE to MOVE on an accepted press
- MOVE to SPAWN
- SPAWN to CHECK
- CHECK to WON, LOST or IDLE, lasting exactly 1 cycle
REQ-018 A press SHALL be a rising edge: the button is high this cycle and its previous-cycle register is low; previous-cycle registers update every cycle in every state.
REQ-019 Presses SHALL be accepted only in IDLE; edges in any other state are discarded, not queued.
REQ-020 When several direction edges occur in the same cycle, priority SHALL be up, then down, then left, then right, and exactly one direction is latched.
REQ-021 A press accepted at rising edge k SHALL produce the direction selector from edge k onward, so it is visible in the cycle after edge k.
REQ-022 In CHECK, if gano=1 the FSM SHALL go to WON; otherwise if perdio=1 it goes to LOST; otherwise it goes to IDLE. Win has priority when both flags are set.
REQ-023 WON and LOST SHALL be terminal for direction buttons.
REQ-024 A btn_restart edge in any state SHALL go to INIT on the next edge. Restart takes priority over a simultaneous direction edge.
REQ-025 On every INIT entry, condicion_gane SHALL latch cfg_win_exp, or WIN_EXP_DEFAULT if cfg_win_exp is 0; the value is stable until the next INIT.
REQ-026 move_count SHALL increment by 1 on each MOVE to SPAWN transition, saturate at 16'hFFFF, and clear on INIT entry.
REQ-027 Status flags SHALL be:
- busy=0 only in IDLE, WON and LOST
- game_won=1 only in WON
- game_lost=1 only in LOST

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL enter INIT with the following values:
- dwell counter reloaded
- selector=000
- condicion_gane latched per REQ-025
- move_count=0
- busy=1, game_won=0, game_lost=0
- all previous-button registers set to 0
REQ-029 rst asserted mid-move, mid-spawn or in a terminal state SHALL abort that state immediately, with no partial move counted.
REQ-030 After rst deasserts with SETTLE_CYCLES=2, the selector SHALL follow 000,000,111,111,101 over cycles 0-4, and busy SHALL fall in cycle 4.

Verification
REQ-031 Reset, cfg_win_exp=4'b1011, no buttons -> selector 000,000,111,111, then 101 held; condicion_gane=1011; busy=0 from cycle 4.
REQ-032 In IDLE, btn_up pulses for 1 cycle -> selector 011,011,111,111,101; move_count=1; gano=perdio=0 -> back to IDLE.
REQ-033 btn_left and btn_down rise in the same IDLE cycle -> selector 100 (down wins); btn_right pressed during SPAWN -> ignored, move_count +1 only.
REQ-034 gano=1 and perdio=1 during CHECK -> game_won=1, game_lost=0, selector 101; later direction presses -> no change.
REQ-035 In LOST, btn_restart pulses with cfg_win_exp=0 -> INIT, condicion_gane=1011, move_count=0, game_lost=0.
REQ-036 rst asserted during MOVE -> next cycle selector=000, move_count=0; move_count forced to 16'hFFFF plus one more move -> stays FFFF.
